// File: rtl/dc_offset_loop.sv
// DC-offset correction loop: measures the DC error accumulator over fixed windows,
// integrates each window's mean into dc_offset and removes that offset from the sample stream.
module dc_offset_loop #(
  parameter int WIN_LOG2   = 21,
  parameter int GAIN_SHIFT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic signed [17:0] sample_in,
  input  logic signed [38:0] acc_dc_err,
  input  logic               freeze,
  output logic signed [17:0] sample_out,
  output logic signed [17:0] dc_offset,
  output logic               acc_clear,
  output logic               update_strobe
);
  localparam int DATA_W = 18;
  localparam int ACC_W  = 39;

  localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]  ACC_HI   = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_LO   = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {RUN, SETTLE, UPDATE, CLEAR} state_t;

  state_t                   state, state_nxt;
  logic [WIN_LOG2-1:0]      win_cnt;
  logic signed [ACC_W-1:0]  acc_lat;
  logic signed [DATA_W-1:0] sample_p1;
  logic signed [ACC_W-1:0]  mean_full;
  logic signed [DATA_W-1:0] mean;
  logic signed [DATA_W-1:0] step;
  logic signed [DATA_W:0]   upd_sum;
  logic signed [DATA_W:0]   corr_diff;

  function automatic logic signed [DATA_W-1:0] sat_mean(input logic signed [ACC_W-1:0] v);
    if (v > ACC_HI)
      return DATA_MAX;
    else if (v < ACC_LO)
      return DATA_MIN;
    else
      return v[DATA_W-1:0];
  endfunction

  // One guard bit: sign disagreement with the next bit means the 18-bit range overflowed.
  function automatic logic signed [DATA_W-1:0] sat_wide(input logic signed [DATA_W:0] v);
    if (v[DATA_W] != v[DATA_W-1])
      return v[DATA_W] ? DATA_MIN : DATA_MAX;
    else
      return v[DATA_W-1:0];
  endfunction

  always_comb begin
    mean_full = acc_lat >>> WIN_LOG2;
    mean      = sat_mean(mean_full);
    step      = mean >>> GAIN_SHIFT;
    upd_sum   = {dc_offset[DATA_W-1], dc_offset} + {step[DATA_W-1], step};
    corr_diff = {sample_in[DATA_W-1], sample_in} - {dc_offset[DATA_W-1], dc_offset};
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (clk_en && (&win_cnt)) state_nxt = SETTLE;
      SETTLE:  if (clk_en) state_nxt = UPDATE;
      UPDATE:  state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Window control and offset integrator
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt       <= '0;
      acc_lat       <= '0;
      dc_offset     <= '0;
      acc_clear     <= 1'b0;
      update_strobe <= 1'b0;
    end else begin
      acc_clear     <= (state == CLEAR);
      update_strobe <= (state == UPDATE) && !freeze;
      if (state == RUN && clk_en)
        win_cnt <= win_cnt + {{(WIN_LOG2-1){1'b0}}, 1'b1};
      else if (state == CLEAR)
        win_cnt <= '0;
      if (state == SETTLE && clk_en)
        acc_lat <= acc_dc_err;
      if (state == UPDATE && !freeze)
        dc_offset <= sat_wide(upd_sum);
    end
  end

  // Correction stage p1: one enabled cycle of latency
  always_ff @(posedge clk) begin
    if (reset)
      sample_p1 <= '0;
    else if (clk_en)
      sample_p1 <= sat_wide(corr_diff);
  end

  assign sample_out = sample_p1;
endmodule

// File: doc/dc_offset_loop.md
# dc_offset_loop

Closes the DC-offset correction loop around the DC error accumulator in the MOD465 receive path. It counts fixed measurement windows of enabled symbol cycles. At the end of each window it reads the accumulator's registered sum, converts it to a mean error, and updates a signed offset register through a shift-gain integrator. It then pulses a clear to the accumulator and subtracts the current offset from the incoming sample stream.

## Interface

- `WIN_LOG2`, default 21: window length is 2^WIN_LOG2 enabled cycles. Equals the LFSR length used by the accumulator.
- `GAIN_SHIFT`, default 2: loop gain is 2^-GAIN_SHIFT applied to the per-window mean.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; clears all state.
- `clk_en` in 1: symbol-rate enable; sample path and window counter advance only when high.
- `sample_in` in 18 signed: uncorrected sample.
- `acc_dc_err` in 39 signed: registered accumulated error from the DC error accumulator.
- `freeze` in 1: inhibits offset updates; windows and clears still run.
- `sample_out` out 18 signed: registered, saturated `sample_in - dc_offset`.
- `dc_offset` out 18 signed: current offset estimate.
- `acc_clear` out 1: one-clk pulse that clears the accumulator; OR'd into the accumulator's reset.
- `update_strobe` out 1: one-clk pulse when `dc_offset` is rewritten.

## Operation

- FSM states: RUN, SETTLE, UPDATE, CLEAR.
- **RUN**: `win_cnt` (WIN_LOG2 bits) increments on each `clk_en`.
  - On `clk_en` with `win_cnt == 2^WIN_LOG2-1`, go to SETTLE.
- **SETTLE**: waits for the next `clk_en`, because the accumulator output register lags its sum by one enable.
  - On that edge, latch `acc_dc_err` into `acc_lat` and go to UPDATE.
  - While `clk_en` is low, stay in SETTLE indefinitely.
- **UPDATE**: lasts one clk, not gated by `clk_en`.
  - `mean = acc_lat >>> WIN_LOG2` (arithmetic; rounds toward -inf); take the low 18 bits after sign-checked saturation to ±(2^17-1)/-2^17.
  - `step = mean >>> GAIN_SHIFT`.
  - If `freeze` is low: `dc_offset <= sat18(dc_offset + step)` using a 19-bit intermediate, and pulse `update_strobe`.
  - If `freeze` is high: `dc_offset` is unchanged and there is no strobe.
  - Go to CLEAR.
- **CLEAR**: `acc_clear = 1` for exactly one clk; `win_cnt <= 0`; go to RUN.
- Error samples the accumulator absorbs during SETTLE/UPDATE/CLEAR are discarded by the clear (blanking interval); this is intended.
- **Sample path**, on each `clk_en`: `sample_out <= sat18(sample_in - dc_offset)`.
  - Saturation limits are +131071 and -131072.
  - Uses `dc_offset` as it stands at that edge.
- **Reset values**:
  - `sample_out` = 0, `dc_offset` = 0, `acc_clear` = 0, `update_strobe` = 0.
  - State = RUN, `win_cnt` = 0, `acc_lat` = 0.
  - Reset overrides every state, including mid-window, SETTLE and CLEAR. An `acc_clear` pulse in progress is dropped.
- `freeze` is sampled only in UPDATE.

## Timing

- Sample path latency: 1 enabled cycle.
- Window end to SETTLE: the edge of the 2^WIN_LOG2-th enabled cycle.
- SETTLE to UPDATE: the next `clk_en` edge (≥1 clk).
- UPDATE to CLEAR: 1 clk. CLEAR to RUN: 1 clk.
- `dc_offset` new value is visible the clk after UPDATE; `sample_out` reflects it at the first `clk_en` edge after that.
- `update_strobe` and `dc_offset` change on the same edge.
- `acc_clear` is high during the clk after `update_strobe`.
- The first counted sample of the next window is the first `clk_en` in RUN (`win_cnt` 0→1).
- `clk_en` high during UPDATE or CLEAR does not advance `win_cnt`; the sample path still updates.

## Test plan

- **Basic window.** WIN_LOG2=4, GAIN_SHIFT=0, behavioural accumulator model, err = +100 constant, `clk_en` always high.
  - Expect `acc_lat` = 1600 and `dc_offset` = 100.
  - Expect `update_strobe` followed by `acc_clear`, each 1 clk.
  - With `sample_in` = 500, expect `sample_out` = 400 thereafter.
- **Negative rounding.** WIN_LOG2=4, GAIN_SHIFT=1, `acc_dc_err` = -17 at SETTLE.
  - Expect mean = -2, step = -1, `dc_offset` = -1.
- **Saturation.** Preload `dc_offset` to 131000 via repeated windows, then force step = +200.
  - Expect `dc_offset` = 131071.
  - With `sample_in` = -131072, expect `sample_out` = -131072.
- **Freeze.** `freeze` = 1 for one window with mean 50.
  - Expect `dc_offset` unchanged, no `update_strobe`, and `acc_clear` still pulses.
- **Stall and reset.** `clk_en` = 1 cycle in 4.
  - Expect the window to span 64 clks at WIN_LOG2=4, and SETTLE to hold until the next `clk_en`.
  - Assert `reset` in SETTLE: expect all outputs 0, state RUN, and no `acc_clear` on the following clk.
